alu_stream_wide: RTL and testbench
==================================

Name: alu_stream_wide

Overview:
- Parametrised, sequential successor to the 8-bit pin-level ALU wrapper.
- Computes a WIDTH-bit integer ALU operation on operands streamed in byte-serially over an 8-bit pad bus, LSB byte first.
- Returns the result byte-serially with a valid/ready handshake plus registered status flags.
- Sits between the 8-bit top-level I/O and the wide datapath of the 32-bit floating-point ALU effort; its integer core also serves as the FP mantissa/exponent helper.

Parameters:
- WIDTH, 32: operand/result width in bits; multiple of 8, range 8..64.
- NB, WIDTH/8: derived beats per operand; not to be overridden.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  8  operand byte
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts a byte this cycle
- op  input  3  operation code; sampled on the first A-byte transfer only
- out_data  output  8  result byte
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- flag_c  output  1  carry / no-borrow
- flag_z  output  1  result == 0
- flag_v  output  1  signed overflow
- busy  output  1  high in every state except LOAD_A with zero bytes received

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous, active-high, clock `clk`, reset `rst`.
- Transfers:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- State machine: LOAD_A → LOAD_B → EXEC → OUT → LOAD_A.
  - LOAD_A: in_ready=1. Each transfer shifts the byte into A at position beat_cnt. The first transfer (beat_cnt=0) also latches op. After NB transfers, clear beat_cnt and go to LOAD_B.
  - LOAD_B: in_ready=1. Same as LOAD_A for B. After NB transfers go to EXEC.
  - EXEC: exactly one cycle, in_ready=0. Compute result R and update the flags register, then go to OUT with beat_cnt=0.
  - OUT: out_valid=1, out_data = R byte beat_cnt (LSB first).
    - out_data is held stable while out_ready=0.
    - Each output transfer advances beat_cnt.
    - After the NB-th transfer, out_valid drops in the next cycle and the state returns to LOAD_A.
- Latency: last B transfer in cycle t → EXEC in t+1 → first out_valid in t+2. Minimum transaction length is 2·NB + 1 + NB cycles.
- Ops (unsigned unless stated):
  - 000 ADD: R = A+B; C = carry out of bit WIDTH-1; V = signed overflow.
  - 001 SUB: R = A−B; C = 1 when A ≥ B (no borrow); V = signed overflow.
  - 010 AND, 011 OR, 100 XOR: C=0, V=0.
  - 101 SHL: R = A << B[log2(WIDTH)-1:0]; C = last bit shifted out (0 for a shift of 0); V=0.
  - 110 SHR (logical): R = A >> B[log2(WIDTH)-1:0]; C = last bit shifted out; V=0.
  - 111 CMP: R = {WIDTH-1 zeros, A<B}; C = (A ≥ B); V = 0.
- Z = (R == 0) for all ops.
- Flags are registered in EXEC and held until the next EXEC. Flag reset value is 0.
- Reset values: state=LOAD_A, beat_cnt=0, A=B=R=0, op=000, in_ready=0 during the reset cycle and 1 after, out_valid=0, out_data=0, flags=0, busy=0.
- Boundary conditions:
  - Reset mid-load or mid-OUT discards all partial data; the next accepted byte is A byte 0.
  - Bytes presented while in_ready=0 (EXEC/OUT) are not consumed.
  - out_ready may be asserted with out_valid=0; this has no effect.
  - beat_cnt wraps to 0 at every phase boundary, never at NB.
  - WIDTH=8 degenerates to single-beat phases; behaviour is otherwise identical.

Test Plan:
- WIDTH=32, ADD, A=0xFFFFFFFF, B=0x00000001 → out bytes 00,00,00,00; C=1, Z=1, V=0; first out_valid exactly 2 cycles after the last B byte.
- ADD A=0x7FFFFFFF, B=1 → bytes 00,00,00,80; V=1, C=0, Z=0. Then SUB A=5, B=7 → bytes FE,FF,FF,FF; C=0, V=0.
- SHL A=0x00000001, B=0x00000023 → shift amount 3 → bytes 08,00,00,00; C=0. SHR A=0x00000003, B=1 → 01,00,00,00; C=1.
- Backpressure: hold out_ready=0 for 3 cycles on byte 1 → out_data and out_valid stable, no byte skipped or repeated. Toggle in_valid randomly during load → result unchanged.
- Assert rst after 2 B bytes, then run CMP A=2, B=3 → R=1, C=0; no stale bytes from the aborted transaction.
- Change op mid-load (after A byte 0) → the op latched on the first A byte is used.

Source files
------------

// File: rtl/alu_stream_wide_if.sv
// Byte-serial operand/result bus of alu_stream_wide, including op code, flags and busy.
// The master drives operands and result backpressure; the slave is the ALU.
interface alu_stream_wide_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       flag_c;
  logic       flag_z;
  logic       flag_v;
  logic       busy;

  modport master (
    output in_data, in_valid, op, out_ready,
    input  in_ready, out_data, out_valid, flag_c, flag_z, flag_v, busy
  );

  modport slave (
    input  in_data, in_valid, op, out_ready,
    output in_ready, out_data, out_valid, flag_c, flag_z, flag_v, busy
  );
endinterface

// File: rtl/alu_stream_wide.sv
// WIDTH-bit integer ALU fed byte-serially (LSB first): load A, load B, one EXEC cycle,
// then stream the result out under valid/ready with flags registered at EXEC.
module alu_stream_wide #(
  parameter  int WIDTH = 32,
  localparam int NB    = WIDTH / 8
) (
  input  logic              clk,
  input  logic              rst,
  alu_stream_wide_if.slave  bus
);

  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, EXEC, OUT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    beat_q, beat_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             c_q, c_d, z_q, z_d, v_q, v_d;

  logic [WIDTH-1:0] a_val, b_val;
  logic             in_ready, out_valid, in_xfer, out_xfer, last_beat;

  assign in_ready  = !rst && (state_q == LOAD_A || state_q == LOAD_B);
  assign out_valid = !rst && (state_q == OUT);
  assign in_xfer   = bus.in_valid && in_ready;
  assign out_xfer  = out_valid && bus.out_ready;
  assign last_beat = (beat_q == CW'(NB - 1));

  // Each operand byte lane owns its register, written only when its beat is transferred.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] a_byte_q, b_byte_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          a_byte_q <= 8'h00;
          b_byte_q <= 8'h00;
        end else if (in_xfer && beat_q == CW'(gi)) begin
          if (state_q == LOAD_A) a_byte_q <= bus.in_data;
          if (state_q == LOAD_B) b_byte_q <= bus.in_data;
        end
      end
      assign a_val[gi*8 +: 8] = a_byte_q;
      assign b_val[gi*8 +: 8] = b_byte_q;
    end
  endgenerate

  logic [WIDTH:0]   sum_ext, diff_ext, shl_ext, shr_ext;
  logic [SW-1:0]    sh;
  logic [WIDTH-1:0] res;
  logic             res_c, res_v;

  always_comb begin
    sh       = b_val[SW-1:0];
    sum_ext  = {1'b0, a_val} + {1'b0, b_val};
    diff_ext = {1'b0, a_val} - {1'b0, b_val};
    // The extra bit catches the last bit shifted out; a zero shift yields carry 0.
    shl_ext  = {1'b0, a_val} << sh;
    shr_ext  = {a_val, 1'b0} >> sh;
    res      = '0;
    res_c    = 1'b0;
    res_v    = 1'b0;
    case (op_q)
      3'b000: begin
        res   = sum_ext[WIDTH-1:0];
        res_c = sum_ext[WIDTH];
        res_v = (a_val[WIDTH-1] == b_val[WIDTH-1]) && (sum_ext[WIDTH-1] != a_val[WIDTH-1]);
      end
      3'b001: begin
        res   = diff_ext[WIDTH-1:0];
        res_c = !diff_ext[WIDTH];
        res_v = (a_val[WIDTH-1] != b_val[WIDTH-1]) && (diff_ext[WIDTH-1] != a_val[WIDTH-1]);
      end
      3'b010: res = a_val & b_val;
      3'b011: res = a_val | b_val;
      3'b100: res = a_val ^ b_val;
      3'b101: begin
        res   = shl_ext[WIDTH-1:0];
        res_c = shl_ext[WIDTH];
      end
      3'b110: begin
        res   = shr_ext[WIDTH:1];
        res_c = shr_ext[0];
      end
      default: begin
        res   = {{(WIDTH-1){1'b0}}, diff_ext[WIDTH]};
        res_c = !diff_ext[WIDTH];
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    op_d    = op_q;
    r_d     = r_q;
    c_d     = c_q;
    z_d     = z_q;
    v_d     = v_q;
    case (state_q)
      LOAD_A: if (in_xfer) begin
        if (beat_q == '0) op_d = bus.op;
        if (last_beat) begin
          beat_d  = '0;
          state_d = LOAD_B;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      LOAD_B: if (in_xfer) begin
        if (last_beat) begin
          beat_d  = '0;
          state_d = EXEC;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      EXEC: begin
        r_d     = res;
        c_d     = res_c;
        z_d     = (res == '0);
        v_d     = res_v;
        beat_d  = '0;
        state_d = OUT;
      end
      default: if (out_xfer) begin
        if (last_beat) begin
          beat_d  = '0;
          state_d = LOAD_A;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_A;
      beat_q  <= '0;
      op_q    <= 3'b000;
      r_q     <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      op_q    <= op_d;
      r_q     <= r_d;
      c_q     <= c_d;
      z_q     <= z_d;
      v_q     <= v_d;
    end
  end

  logic [7:0] out_byte;
  always_comb begin
    out_byte = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (beat_q == CW'(i)) out_byte = r_q[i*8 +: 8];
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? out_byte : 8'h00;
  assign bus.flag_c    = c_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_v    = v_q;
  assign bus.busy      = !rst && !(state_q == LOAD_A && beat_q == '0);

endmodule

// File: tb/tb_alu_stream_wide.sv
// Directed bench for alu_stream_wide at WIDTH=32: each task runs one scenario and checks inline.
module tb_alu_stream_wide;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  alu_stream_wide_if bus ();
  alu_stream_wide #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic send_byte(input logic [7:0] d, input bit gap);
    int n;
    @(negedge clk);
    if (gap) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout in_ready got %b want 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                           input bit change_op, input logic [2:0] op_alt, input bit gap);
    bus.op = op;
    for (int i = 0; i < 4; i++) begin
      send_byte(a[i*8 +: 8], gap);
      if (i == 0 && change_op) bus.op = op_alt;
    end
    for (int i = 0; i < 4; i++) send_byte(b[i*8 +: 8], gap);
  endtask

  task automatic recv_word(output logic [31:0] r, input int stall_beat);
    int n;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n = 0;
      while (!bus.out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!bus.out_valid) begin
        tests++;
        fails++;
        $display("FAIL recv_timeout out_valid got %b want 1", bus.out_valid);
      end
      r[i*8 +: 8] = bus.out_data;
      if (i == stall_beat) begin
        bus.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          tests++;
          if (bus.out_valid !== 1'b1 || bus.out_data !== r[i*8 +: 8]) begin
            fails++;
            $display("FAIL stall_hold valid/data got %b/%h want 1/%h",
                     bus.out_valid, bus.out_data, r[i*8 +: 8]);
          end
        end
        bus.out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.op        = 3'b000;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_in_ready_during got %b want 0", bus.in_ready);
    end
    rst = 1'b0;
    #1;
    tests++;
    if ({bus.in_ready, bus.out_valid, bus.out_data, bus.busy} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL reset_outputs in_ready/out_valid/out_data/busy got %b/%b/%h/%b want 1/0/00/0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.busy);
    end
    tests++;
    if ({bus.flag_c, bus.flag_z, bus.flag_v} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags czv got %b want 000", {bus.flag_c, bus.flag_z, bus.flag_v});
    end
    $display("[TB] txn reset done");
  endtask

  task automatic test_add_carry_latency();
    logic [31:0] r;
    send_word(32'hFFFF_FFFF, 32'h0000_0001, 3'b000, 1'b0, 3'b000, 1'b0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b001) begin
      fails++;
      $display("FAIL exec_cycle out_valid/in_ready/busy got %b%b%b want 001",
               bus.out_valid, bus.in_ready, bus.busy);
    end
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL latency out_valid got %b want 1", bus.out_valid);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    recv_word(r, -1);
    $display("[TB] txn ADD a=ffffffff b=00000001 r=%h czv=%b", r, {bus.flag_c, bus.flag_z, bus.flag_v});
    tests++;
    if (r !== 32'h0000_0000 || {bus.flag_c, bus.flag_z, bus.flag_v} !== 3'b110) begin
      fails++;
      $display("FAIL add_carry r/czv got %h/%b want 00000000/110", r, {bus.flag_c, bus.flag_z, bus.flag_v});
    end
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL out_done out_valid/busy got %b/%b want 0/0", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_arith();
    logic [31:0] r;
    send_word(32'h7FFF_FFFF, 32'h0000_0001, 3'b000, 1'b0, 3'b000, 1'b0);
    bus.in_valid = 1'b0;
    recv_word(r, -1);
    $display("[TB] txn ADD a=7fffffff b=00000001 r=%h czv=%b", r, {bus.flag_c, bus.flag_z, bus.flag_v});
    tests++;
    if (r !== 32'h8000_0000 || {bus.flag_c, bus.flag_z, bus.flag_v} !== 3'b001) begin
      fails++;
      $display("FAIL add_ovf r/czv got %h/%b want 80000000/001", r, {bus.flag_c, bus.flag_z, bus.flag_v});
    end
    send_word(32'h0000_0005, 32'h0000_0007, 3'b001, 1'b0, 3'b000, 1'b0);
    bus.in_valid = 1'b0;
    recv_word(r, -1);
    $display("[TB] txn SUB a=00000005 b=00000007 r=%h czv=%b", r, {bus.flag_c, bus.flag_z, bus.flag_v});
    tests++;
    if (r !== 32'hFFFF_FFFE || {bus.flag_c, bus.flag_z, bus.flag_v} !== 3'b000) begin
      fails++;
      $display("FAIL sub_borrow r/czv got %h/%b want fffffffe/000", r, {bus.flag_c, bus.flag_z, bus.flag_v});
    end
  endtask

  task automatic test_shift();
    logic [31:0] r;
    send_word(32'h0000_0001, 32'h0000_0023, 3'b101, 1'b0, 3'b000, 1'b0);
    bus.in_valid = 1'b0;
    recv_word(r, -1);
    $display("[TB] txn SHL a=00000001 b=00000023 r=%h czv=%b", r, {bus.flag_c, bus.flag_z, bus.flag_v});
    tests++;
    if (r !== 32'h0000_0008 || {bus.flag_c, bus.flag_z, bus.flag_v} !== 3'b000) begin
      fails++;
      $display("FAIL shl r/czv got %h/%b want 00000008/000", r, {bus.flag_c, bus.flag_z, bus.flag_v});
    end
    send_word(32'h0000_0003, 32'h0000_0001, 3'b110, 1'b0, 3'b000, 1'b0);
    bus.in_valid = 1'b0;
    recv_word(r, -1);
    $display("[TB] txn SHR a=00000003 b=00000001 r=%h czv=%b", r, {bus.flag_c, bus.flag_z, bus.flag_v});
    tests++;
    if (r !== 32'h0000_0001 || {bus.flag_c, bus.flag_z, bus.flag_v} !== 3'b100) begin
      fails++;
      $display("FAIL shr r/czv got %h/%b want 00000001/100", r, {bus.flag_c, bus.flag_z, bus.flag_v});
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r;
    send_word(32'h1234_5678, 32'h0F0F_0F0F, 3'b100, 1'b0, 3'b000, 1'b1);
    bus.in_valid = 1'b0;
    recv_word(r, 1);
    $display("[TB] txn XOR a=12345678 b=0f0f0f0f r=%h czv=%b", r, {bus.flag_c, bus.flag_z, bus.flag_v});
    tests++;
    if (r !== 32'h1D3B_5977 || {bus.flag_c, bus.flag_z, bus.flag_v} !== 3'b000) begin
      fails++;
      $display("FAIL xor_stall r/czv got %h/%b want 1d3b5977/000", r, {bus.flag_c, bus.flag_z, bus.flag_v});
    end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] r;
    bus.op = 3'b011;
    for (int i = 0; i < 4; i++) send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 2; i++) send_byte(8'h5A, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_state busy/in_ready got %b/%b want 0/1", bus.busy, bus.in_ready);
    end
    send_word(32'h0000_0002, 32'h0000_0003, 3'b111, 1'b0, 3'b000, 1'b0);
    bus.in_valid = 1'b0;
    recv_word(r, -1);
    $display("[TB] txn CMP a=00000002 b=00000003 r=%h czv=%b", r, {bus.flag_c, bus.flag_z, bus.flag_v});
    tests++;
    if (r !== 32'h0000_0001 || {bus.flag_c, bus.flag_z, bus.flag_v} !== 3'b000) begin
      fails++;
      $display("FAIL cmp_after_abort r/czv got %h/%b want 00000001/000", r, {bus.flag_c, bus.flag_z, bus.flag_v});
    end
  endtask

  task automatic test_op_latch();
    logic [31:0] r;
    send_word(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b010, 1'b1, 3'b011, 1'b0);
    bus.in_valid = 1'b0;
    recv_word(r, -1);
    $display("[TB] txn AND(op->OR mid-load) a=f0f0f0f0 b=ff00ff00 r=%h", r);
    tests++;
    if (r !== 32'hF000_F000) begin
      fails++;
      $display("FAIL op_latch r got %h want f000f000", r);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    send_word(32'h0000_1000, 32'h0000_0234, 3'b011, 1'b0, 3'b000, 1'b0);
    bus.in_data = 8'hAA;
    recv_word(r, -1);
    bus.in_valid = 1'b0;
    $display("[TB] txn OR a=00001000 b=00000234 r=%h (junk bytes offered)", r);
    tests++;
    if (r !== 32'h0000_1234) begin
      fails++;
      $display("FAIL or_junk r got %h want 00001234", r);
    end
    send_word(32'h0000_0009, 32'h0000_0009, 3'b001, 1'b0, 3'b000, 1'b0);
    bus.in_valid = 1'b0;
    recv_word(r, -1);
    $display("[TB] txn SUB a=00000009 b=00000009 r=%h czv=%b", r, {bus.flag_c, bus.flag_z, bus.flag_v});
    tests++;
    if (r !== 32'h0000_0000 || {bus.flag_c, bus.flag_z, bus.flag_v} !== 3'b110) begin
      fails++;
      $display("FAIL sub_equal r/czv got %h/%b want 00000000/110", r, {bus.flag_c, bus.flag_z, bus.flag_v});
    end
  endtask

  initial begin
    test_reset();
    test_add_carry_latency();
    test_arith();
    test_shift();
    test_backpressure();
    test_reset_mid_load();
    test_op_latch();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
